crc_stream_arbiter: RTL

- Shares one byte-serial CRC-32 engine (reflected poly 0xEDB88320, init 0xFFFFFFFF, final XOR, auto-reseed after last byte) between NCH packet streams.
- Arbitration is packet-granular round-robin: a granted channel keeps the engine until its last byte.
- The block waits for the engine result, then returns CRC, channel ID and byte count on a held result port.
- Sits between the per-channel framers and the CRC engine instance.

---
 rtl/crc_stream_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/crc_stream_arbiter.sv
// Packet-granular round-robin arbiter sharing one byte-serial CRC-32 engine
// between NCH framer streams; returns CRC, channel and length on a held port.
module crc_stream_arbiter #(
    parameter int NCH     = 4,
    parameter int CHW     = 2,
    parameter int TIMEOUT = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NCH-1:0]     s_valid,
    input  logic [NCH*8-1:0]   s_data,
    input  logic [NCH-1:0]     s_last,
    output logic [NCH-1:0]     s_ready,
    output logic               eng_valid,
    output logic [7:0]         eng_data,
    output logic               eng_last,
    input  logic               eng_done,
    input  logic [31:0]        eng_crc,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [31:0]        res_crc,
    output logic [CHW-1:0]     res_chan,
    output logic [15:0]        res_len,
    output logic               res_err,
    output logic               busy
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, STREAM, WAIT, RESP} state_t;

    state_t         state_q, state_d;
    logic [CHW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CHW-1:0] gnt_q, gnt_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic           res_valid_q, res_valid_d;
    logic [31:0]    res_crc_q, res_crc_d;
    logic [CHW-1:0] res_chan_q, res_chan_d;
    logic [15:0]    res_len_q, res_len_d;
    logic           res_err_q, res_err_d;

    logic           pick_found;
    logic [CHW-1:0] pick;
    logic [7:0]     gnt_byte;

    // First requester at or after rr_ptr, wrapping around.
    always_comb begin
        int idx;
        idx        = 0;
        pick_found = 1'b0;
        pick       = '0;
        for (int i = 0; i < NCH; i++) begin
            idx = (int'(rr_ptr_q) + i) % NCH;
            if (!pick_found && s_valid[idx]) begin
                pick_found = 1'b1;
                pick       = CHW'(idx);
            end
        end
    end

    assign gnt_byte = s_data[{gnt_q, 3'b000} +: 8];

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_d       = gnt_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        res_valid_d = res_valid_q;
        res_crc_d   = res_crc_q;
        res_chan_d  = res_chan_q;
        res_len_d   = res_len_q;
        res_err_d   = res_err_q;
        s_ready     = '0;
        eng_valid   = 1'b0;
        eng_data    = '0;
        eng_last    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    gnt_d   = pick;
                    cnt_d   = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                s_ready[gnt_q] = 1'b1;
                eng_valid      = s_valid[gnt_q];
                eng_data       = gnt_byte;
                eng_last       = s_last[gnt_q] & s_valid[gnt_q];
                if (s_valid[gnt_q]) begin
                    if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
                    if (s_last[gnt_q]) begin
                        tmo_d   = '0;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                // The TIMEOUT-th cycle without a done pulse closes the packet as an error.
                if (eng_done || tmo_q == TW'(TIMEOUT - 1)) begin
                    res_valid_d = 1'b1;
                    res_crc_d   = eng_done ? eng_crc : 32'h0;
                    res_err_d   = !eng_done;
                    res_chan_d  = gnt_q;
                    res_len_d   = cnt_q;
                    state_d     = RESP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            RESP: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    rr_ptr_d    = (int'(gnt_q) == NCH - 1) ? '0 : gnt_q + 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            gnt_q       <= '0;
            cnt_q       <= '0;
            tmo_q       <= '0;
            res_valid_q <= 1'b0;
            res_crc_q   <= '0;
            res_chan_q  <= '0;
            res_len_q   <= '0;
            res_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_q       <= gnt_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            res_valid_q <= res_valid_d;
            res_crc_q   <= res_crc_d;
            res_chan_q  <= res_chan_d;
            res_len_q   <= res_len_d;
            res_err_q   <= res_err_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_crc   = res_crc_q;
    assign res_chan  = res_chan_q;
    assign res_len   = res_len_q;
    assign res_err   = res_err_q;
    assign busy      = (state_q != IDLE);

endmodule
